// File: rtl/rm_mul_pkg.sv
// Shared definitions for the recursive 2x2-digit multiplier.
//   DIGIT_W    : digit width used by the partial-product decomposition
//   pp_t       : one 4-bit digit partial product
//   mode_e     : operand signedness combination {a_signed, b_signed}
//   ndig()     : number of digits per operand for a given operand width
//   corr_const : constant that undoes the inverted-MSB coding of signed rows
package rm_mul_pkg;

  localparam int DIGIT_W = 2;
  localparam int MAX_W   = 16;

  typedef logic [3:0] pp_t;

  typedef enum logic [1:0] {
    MODE_UU = 2'b00,
    MODE_US = 2'b01,
    MODE_SU = 2'b10,
    MODE_SS = 2'b11
  } mode_e;

  function automatic int ndig(input int width);
    return width / DIGIT_W;
  endfunction

  // A signed digit product p (weight 2^s) is summed as {~p[3], p[2:0]}, which
  // equals p + 2^(s+3). Subtracting 2^(s+3) once per signed row restores the
  // exact sum, so no row ever needs sign extension.
  function automatic logic [2*MAX_W-1:0] corr_const(input int width,
                                                    input logic a_signed,
                                                    input logic b_signed);
    logic [2*MAX_W-1:0] c;
    int nd;
    c  = '0;
    nd = ndig(width);
    for (int i = 0; i < nd; i++) begin
      for (int j = 0; j < nd; j++) begin
        if ((a_signed && (i == nd - 1)) || (b_signed && (j == nd - 1))) begin
          c = c - ((2*MAX_W)'(1) << (2*(i + j) + 3));
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/rm_pp_digit.sv
// 2x2-digit partial product.
//   a, b   : operand digits
//   sa, sb : 1 when the corresponding digit is the signed top digit
//   p      : 4-bit product, two's complement whenever sa | sb
module rm_pp_digit
  import rm_mul_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sa,
  input  logic               sb,
  output pp_t                p
);

  logic signed [DIGIT_W:0] a_ext;
  logic signed [DIGIT_W:0] b_ext;
  logic signed [3:0]       prod;

  // Range is -6..9 across all four modes, so 4 bits always hold the product
  // (unsigned for uu, two's complement otherwise).
  always_comb begin
    a_ext = {sa & a[DIGIT_W-1], a};
    b_ext = {sb & b[DIGIT_W-1], b};
    prod  = 4'(a_ext) * 4'(b_ext);
    p     = prod;
  end

endmodule

// File: rtl/rm_mul_pipe.sv
// Pipelined exact WIDTHxWIDTH multiplier with per-operand signed/unsigned mode.
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : operand handshake
//   in_a, in_b                   : operands
//   in_a_signed, in_b_signed     : 1 = two's complement, 0 = unsigned
//   out_valid/out_ready          : product handshake
//   out_p                        : exact 2*WIDTH-bit product
//   busy                         : any stage holds a beat
// Stage layout: STAGES=3 [digit PPs | reduction to 2 rows | CPA],
// STAGES=2 [PPs + reduction | CPA], STAGES=1 [everything | output reg].
module rm_mul_pipe
  import rm_mul_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_a_signed,
  input  logic               in_b_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int NDIG  = ndig(WIDTH);
  localparam int NPP   = NDIG * NDIG;
  localparam int NROWS = NPP + 1;
  localparam int PW    = 2 * WIDTH;

  localparam logic [PW-1:0] CORR_US = PW'(corr_const(WIDTH, 1'b0, 1'b1));
  localparam logic [PW-1:0] CORR_SU = PW'(corr_const(WIDTH, 1'b1, 1'b0));
  localparam logic [PW-1:0] CORR_SS = PW'(corr_const(WIDTH, 1'b1, 1'b1));

  // Handshake: stage k loads when it is empty or its successor moves on.
  logic [STAGES-1:0] vld_q, vld_d, vin, ld;
  logic [STAGES:0]   rdy;

  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~vld_q[k] | rdy[k+1];
    end
    vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      vin[k] = vld_q[k-1];
    end
    ld    = vin & rdy[STAGES-1:0];
    vld_d = (rdy[STAGES-1:0] & vin) | (~rdy[STAGES-1:0] & vld_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES-1];
  assign busy      = |vld_q;

  // Digit partial products
  pp_t [NPP-1:0] pp_raw;
  pp_t [NPP-1:0] pp_p0_d;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig_a
    for (genvar j = 0; j < NDIG; j++) begin : g_dig_b
      localparam logic TOP_I = (i == NDIG - 1);
      localparam logic TOP_J = (j == NDIG - 1);
      rm_pp_digit u_dig (
        .a  (in_a[2*i +: 2]),
        .b  (in_b[2*j +: 2]),
        .sa (in_a_signed & TOP_I),
        .sb (in_b_signed & TOP_J),
        .p  (pp_raw[i*NDIG + j])
      );
    end
  end

  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      for (int j = 0; j < NDIG; j++) begin
        if ((in_a_signed && (i == NDIG - 1)) || (in_b_signed && (j == NDIG - 1)))
          pp_p0_d[i*NDIG + j] = {~pp_raw[i*NDIG + j][3], pp_raw[i*NDIG + j][2:0]};
        else
          pp_p0_d[i*NDIG + j] = pp_raw[i*NDIG + j];
      end
    end
  end

  pp_t [NPP-1:0] pp_r;
  logic          a_s_r, b_s_r;

  // ---- stage p0 boundary (STAGES=3 only) ----
  if (STAGES == 3) begin : g_p0
    pp_t [NPP-1:0] pp_p0_q;
    logic          a_s_p0_q, b_s_p0_q;
    always_ff @(posedge clk) begin
      if (ld[0]) begin
        pp_p0_q  <= pp_p0_d;
        a_s_p0_q <= in_a_signed;
        b_s_p0_q <= in_b_signed;
      end
    end
    assign pp_r  = pp_p0_q;
    assign a_s_r = a_s_p0_q;
    assign b_s_r = b_s_p0_q;
  end else begin : g_no_p0
    assign pp_r  = pp_p0_d;
    assign a_s_r = in_a_signed;
    assign b_s_r = in_b_signed;
  end

  // Reduction: full-adder layers compress the shifted rows plus the
  // correction row down to two rows.
  logic [PW-1:0] rows [NROWS];
  logic [PW-1:0] nxt  [NROWS];
  logic [PW-1:0] corr;
  logic [PW-1:0] sum_p1_d, cry_p1_d;

  always_comb begin
    corr = '0;
    unique case (mode_e'({a_s_r, b_s_r}))
      MODE_UU: corr = '0;
      MODE_US: corr = CORR_US;
      MODE_SU: corr = CORR_SU;
      MODE_SS: corr = CORR_SS;
    endcase
    for (int k = 0; k < NROWS; k++) begin
      rows[k] = '0;
      nxt[k]  = '0;
    end
    for (int i = 0; i < NDIG; i++) begin
      for (int j = 0; j < NDIG; j++) begin
        rows[i*NDIG + j] = PW'(pp_r[i*NDIG + j]) << (2*(i + j));
      end
    end
    rows[NPP] = corr;
    begin
      int n, m, rem;
      n = NROWS;
      for (int lvl = 0; lvl < NROWS; lvl++) begin
        if (n > 2) begin
          m   = n / 3;
          rem = n % 3;
          for (int g = 0; g < NROWS / 3; g++) begin
            if (g < m) begin
              nxt[2*g]   = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
              nxt[2*g+1] = ((rows[3*g] & rows[3*g+1]) | (rows[3*g] & rows[3*g+2]) |
                            (rows[3*g+1] & rows[3*g+2])) << 1;
            end
          end
          for (int t = 0; t < 2; t++) begin
            if (t < rem) nxt[2*m + t] = rows[3*m + t];
          end
          n = 2*m + rem;
          for (int k = 0; k < NROWS; k++) rows[k] = nxt[k];
        end
      end
    end
    sum_p1_d = rows[0];
    cry_p1_d = rows[1];
  end

  logic [PW-1:0] sum_r, cry_r;

  // ---- stage p1 boundary (STAGES>=2) ----
  if (STAGES >= 2) begin : g_p1
    logic [PW-1:0] sum_p1_q, cry_p1_q;
    always_ff @(posedge clk) begin
      if (ld[STAGES-2]) begin
        sum_p1_q <= sum_p1_d;
        cry_p1_q <= cry_p1_d;
      end
    end
    assign sum_r = sum_p1_q;
    assign cry_r = cry_p1_q;
  end else begin : g_no_p1
    assign sum_r = sum_p1_d;
    assign cry_r = cry_p1_d;
  end

  // Final carry-propagate add
  logic [PW-1:0] out_p_d, out_p_q;

  always_comb begin
    out_p_d = sum_r + cry_r;
  end

  // ---- output stage boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  out_p_q <= '0;
    else if (ld[STAGES-1])    out_p_q <= out_p_d;
  end

  assign out_p = out_p_q;

endmodule

// File: tb/tb_rm_mul_pipe.sv
module tb_rm_mul_pipe;

  localparam int W   = 8;
  localparam int STG = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           in_a_signed = 1'b0;
  logic           in_b_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] out_p;
  logic           busy;

  rm_mul_pipe #(.WIDTH(W), .STAGES(STG)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_a_signed (in_a_signed),
    .in_b_signed (in_b_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_p       (out_p),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             cyc;
    bit             lat;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc = 0;
  bit  lat_mode = 1'b0;
  bit  stall_prev = 1'b0;
  logic [2*W-1:0] p_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sa, input logic sb);
    logic signed [W:0]     ea, eb;
    logic signed [2*W+1:0] pr;
    ea = {sa & a[W-1], a};
    eb = {sb & b[W-1], b};
    pr = ea * eb;
    return pr[2*W-1:0];
  endfunction

  function automatic void push(input logic [2*W-1:0] p);
    sb_q.push_back('{p: p, cyc: cyc, lat: lat_mode});
  endfunction

  // Output monitor: scoreboard pop, latency and hold-while-stalled checks.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_val("hold_valid", out_valid, 1'b1);
        check_val("hold_data", out_p, p_prev);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", sb_q.size(), 1);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check_val("prod", out_p, e.p);
          if (e.lat && lat_mode) check_val("latency", cyc - e.cyc, STG);
        end
      end
      stall_prev = out_valid && !out_ready;
      p_prev     = out_p;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sa, input logic sb, input logic [2*W-1:0] exp);
    bit acc;
    acc = 1'b0;
    in_a = a; in_b = b; in_a_signed = sa; in_b_signed = sb; in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        push(exp);
      end
      @(posedge clk); #1;
    end
    if (!acc) check_val("accept_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && (busy || sb_q.size() != 0); t++) @(negedge clk);
    check_val("drain_busy", busy, 1'b0);
    check_val("drain_sb", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] corner [6];
  logic [W-1:0] ra, rb;
  logic         rsa, rsb;
  logic [1:0]   md;
  int           idx;
  bit           acc;

  initial begin
    corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};

    // Power-on reset
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_out_p", out_p, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rst_in_ready", in_ready, 1'b1);

    // Directed corners, free-flowing output
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    send(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000);
    send(8'h7F, 8'h80, 1'b1, 1'b1, 16'hC080);
    send(8'hFF, 8'h01, 1'b1, 1'b1, 16'hFFFF);
    send(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01);
    send(8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01);
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFF01);
    send(8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001);
    for (int ia = 0; ia < 6; ia++)
      for (int ib = 0; ib < 6; ib++)
        for (int m = 0; m < 4; m++) begin
          md = 2'(m);
          send(corner[ia], corner[ib], md[1], md[0], model(corner[ia], corner[ib], md[1], md[0]));
        end
    wait_drain();

    // Asynchronous reset with three beats in flight
    lat_mode  = 1'b0;
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 1'b0, model(8'h12, 8'h34, 1'b0, 1'b0));
    send(8'h56, 8'h78, 1'b1, 1'b0, model(8'h56, 8'h78, 1'b1, 1'b0));
    send(8'h9A, 8'hBC, 1'b1, 1'b1, model(8'h9A, 8'hBC, 1'b1, 1'b1));
    check_val("inflight_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_val("async_out_valid", out_valid, 1'b0);
    check_val("async_busy", busy, 1'b0);
    check_val("async_out_p", out_p, '0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("post_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    send(8'h3C, 8'hC3, 1'b0, 1'b1, model(8'h3C, 8'hC3, 1'b0, 1'b1));
    wait_drain();

    // Backpressure: continuous input against a stalled output
    lat_mode  = 1'b0;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_a = 8'(8'h11 * (idx + 1)); in_b = 8'(8'hF0 - idx);
      in_a_signed = 1'b1; in_b_signed = idx[0];
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        push(model(in_a, in_b, in_a_signed, in_b_signed));
        idx++;
      end
      @(posedge clk); #1;
    end
    check_val("bp_accepted", idx, STG);
    check_val("bp_in_ready", in_ready, 1'b0);
    check_val("bp_out_valid", out_valid, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < STG; k++) begin
      @(negedge clk);
      check_val("bp_drain_rate", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("bp_drain_done", out_valid, 1'b0);
    @(posedge clk); #1;
    wait_drain();

    // Bubble collapse
    send(8'hA5, 8'h5A, 1'b0, 1'b0, model(8'hA5, 8'h5A, 1'b0, 1'b0));
    repeat (2) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    check_val("bubble_in_ready", in_ready, 1'b1);
    send(8'h81, 8'h7E, 1'b1, 1'b0, model(8'h81, 8'h7E, 1'b1, 1'b0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bubble_first", out_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("bubble_adjacent", out_valid, 1'b1);
    @(posedge clk); #1;
    wait_drain();

    // Random traffic with random valid/ready
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        ra = 8'($urandom()); rb = 8'($urandom());
        rsa = 1'($urandom()); rsb = 1'($urandom());
        in_a = ra; in_b = rb; in_a_signed = rsa; in_b_signed = rsb;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) push(model(in_a, in_b, in_a_signed, in_b_signed));
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
